rename_unit: RTL and testbench

Single-wide register-rename stage that sits directly upstream of the reorder buffer. It maps architectural destinations to fresh physical registers from a free list and updates the RAT. It drives the ROB allocate port with {ard, prd_new, prd_old}. It consumes the ROB commit port, pops each committed entry and returns prd_old to the free list. It also keeps a busy table, cleared by writeback, and reports source-operand readiness.

---
 rtl/rename_unit.sv | 204 ++++++++++++++++++++
 tb/tb_rename_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// ---------------------------------------------------------------------------
// rename_unit
//
// Single-wide register-rename stage placed directly in front of the reorder
// buffer. Each accepted rename does the following:
//   - pops a fresh physical register from a circular free list,
//   - maps the architectural destination to that register in the RAT,
//   - marks the register busy,
//   - hands {ard, prd_new, prd_old} to the ROB in the same cycle.
// Retiring instructions return their prd_old to the free list. Writebacks
// clear busy bits. Source readiness includes a same-cycle writeback bypass.
//
// Ports
//   clk, rst             : clock (rising edge), async active-high reset
//   ren_valid            : rename request present
//   ren_ard              : destination architectural register
//   ren_ars1, ren_ars2   : source architectural registers
//   ren_ready            : rename can be accepted this cycle
//   ren_prd              : allocated physical destination
//   ren_prs1, ren_prs2   : physical sources (pre-update RAT contents)
//   ren_prs1_rdy/_rdy2   : source values available
//   rob_alloc_ok         : ROB has space
//   rob_alloc_en         : ROB allocate strobe
//   rob_ard              : to ROB ard_in
//   rob_prd_new          : to ROB prd_new_in
//   rob_prd_old          : to ROB prd_old_in
//   wb_en, wb_prd        : writeback strobe and written physical register
//   commit_valid         : ROB head ready to retire
//   commit_prd_old       : physical register freed by the retiring instruction
//   commit_pop           : pop ROB head
//   free_cnt             : current free-list occupancy
//   fl_overflow          : sticky error, free-list push while full
// ---------------------------------------------------------------------------
module rename_unit #(
   parameter int ARCH = 32,
   parameter int PHYS = 64,
   parameter int AW   = $clog2(ARCH),
   parameter int PW   = $clog2(PHYS),
   parameter int FLN  = PHYS - ARCH,
   parameter int FW   = $clog2(FLN + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ren_valid,
   input  logic [AW-1:0] ren_ard,
   input  logic [AW-1:0] ren_ars1,
   input  logic [AW-1:0] ren_ars2,
   output logic          ren_ready,
   output logic [PW-1:0] ren_prd,
   output logic [PW-1:0] ren_prs1,
   output logic [PW-1:0] ren_prs2,
   output logic          ren_prs1_rdy,
   output logic          ren_prs2_rdy,
   input  logic          rob_alloc_ok,
   output logic          rob_alloc_en,
   output logic [AW-1:0] rob_ard,
   output logic [PW-1:0] rob_prd_new,
   output logic [PW-1:0] rob_prd_old,
   input  logic          wb_en,
   input  logic [PW-1:0] wb_prd,
   input  logic          commit_valid,
   input  logic [PW-1:0] commit_prd_old,
   output logic          commit_pop,
   output logic [FW-1:0] free_cnt,
   output logic          fl_overflow
);

   localparam int            HW       = (FLN > 1) ? $clog2(FLN) : 1;
   localparam logic [FW-1:0] FULL_CNT = FW'(FLN);
   localparam logic [FW-1:0] CNT_ONE  = FW'(1'b1);
   localparam logic [HW-1:0] LAST_IDX = HW'(FLN - 1);
   localparam logic [HW-1:0] IDX_ONE  = HW'(1'b1);

   // Architectural state
   logic [PW-1:0] rat_r [ARCH];
   logic [PW-1:0] fl_r  [FLN];
   logic [HW-1:0] head_r;
   logic [HW-1:0] tail_r;
   logic [FW-1:0] count_r;
   logic [PHYS-1:0] busy_r;
   logic          fl_overflow_r;

   // Decoded controls
   logic          ren_ready_s;
   logic          fire_s;
   logic          full_s;
   logic          push_s;
   logic          ovf_s;
   logic [PW-1:0] new_prd_s;
   logic [PW-1:0] old_prd_s;
   logic [PW-1:0] prs1_s;
   logic [PW-1:0] prs2_s;
   logic          prs1_rdy_s;
   logic          prs2_rdy_s;
   logic [HW-1:0] head_nxt_s;
   logic [HW-1:0] tail_nxt_s;
   logic [FW-1:0] count_nxt_s;

   // Handshake, RAT lookups and free-list pop/push decode.
   // ren_ready only looks at the registered count, so a commit landing in
   // the same cycle cannot unblock a rename when the list is empty.
   always_comb begin
      ren_ready_s = (count_r != {FW{1'b0}}) && rob_alloc_ok;
      fire_s      = ren_valid && ren_ready_s;
      full_s      = (count_r == FULL_CNT);
      push_s      = commit_valid && !full_s;
      ovf_s       = commit_valid && full_s;
      new_prd_s   = fl_r[head_r];
      old_prd_s   = rat_r[ren_ard];
      prs1_s      = rat_r[ren_ars1];
      prs2_s      = rat_r[ren_ars2];
      // A writeback in flight this cycle makes the operand ready right away
      prs1_rdy_s  = !busy_r[prs1_s] || (wb_en && (wb_prd == prs1_s));
      prs2_rdy_s  = !busy_r[prs2_s] || (wb_en && (wb_prd == prs2_s));
      head_nxt_s  = (head_r == LAST_IDX) ? {HW{1'b0}} : (head_r + IDX_ONE);
      tail_nxt_s  = (tail_r == LAST_IDX) ? {HW{1'b0}} : (tail_r + IDX_ONE);
   end

   // Free-list occupancy: a pop and a push in the same cycle cancel out
   always_comb begin
      count_nxt_s = count_r;
      if (fire_s && !push_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else if (push_s && !fire_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // RAT: identity map at reset, destination remapped on each accepted rename
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ARCH; i++) begin
            rat_r[i] <= PW'(i);
         end
      end else begin
         if (fire_s) begin
            rat_r[ren_ard] <= new_prd_s;
         end
      end
   end

   // Free list storage, pointers and count; a push while full is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < FLN; k++) begin
            fl_r[k] <= PW'(ARCH + k);
         end
         head_r  <= {HW{1'b0}};
         tail_r  <= {HW{1'b0}};
         count_r <= FULL_CNT;
      end else begin
         if (fire_s) begin
            head_r <= head_nxt_s;
         end
         if (push_s) begin
            fl_r[tail_r] <= commit_prd_old;
            tail_r       <= tail_nxt_s;
         end
         count_r <= count_nxt_s;
      end
   end

   // Busy table: writeback clears, rename sets; the set is last so it wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {PHYS{1'b0}};
      end else begin
         if (wb_en) begin
            busy_r[wb_prd] <= 1'b0;
         end
         if (fire_s) begin
            busy_r[new_prd_s] <= 1'b1;
         end
      end
   end

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fl_overflow_r <= 1'b0;
      end else begin
         if (ovf_s) begin
            fl_overflow_r <= 1'b1;
         end
      end
   end

   assign ren_ready    = ren_ready_s;
   assign ren_prd      = new_prd_s;
   assign ren_prs1     = prs1_s;
   assign ren_prs2     = prs2_s;
   assign ren_prs1_rdy = prs1_rdy_s;
   assign ren_prs2_rdy = prs2_rdy_s;
   assign rob_alloc_en = fire_s;
   assign rob_ard      = ren_ard;
   assign rob_prd_new  = new_prd_s;
   assign rob_prd_old  = old_prd_s;
   assign commit_pop   = commit_valid;
   assign free_cnt     = count_r;
   assign fl_overflow  = fl_overflow_r;

endmodule

// File: tb/tb_rename_unit.sv
// ---------------------------------------------------------------------------
// tb_rename_unit
//
// Directed bench for rename_unit. It uses ARCH=32 and PHYS=64. Expected
// values are hand-computed. A small queue stands in for the ROB, holding the
// prd_old of every in-flight rename, so that commits return realistic
// registers and the free-list invariant can be checked.
// ---------------------------------------------------------------------------
module tb_rename_unit;

   localparam int ARCH = 32;
   localparam int PHYS = 64;
   localparam int AW   = 5;
   localparam int PW   = 6;
   localparam int FW   = 6;

   logic          clk;
   logic          rst;
   logic          ren_valid;
   logic [AW-1:0] ren_ard;
   logic [AW-1:0] ren_ars1;
   logic [AW-1:0] ren_ars2;
   logic          ren_ready;
   logic [PW-1:0] ren_prd;
   logic [PW-1:0] ren_prs1;
   logic [PW-1:0] ren_prs2;
   logic          ren_prs1_rdy;
   logic          ren_prs2_rdy;
   logic          rob_alloc_ok;
   logic          rob_alloc_en;
   logic [AW-1:0] rob_ard;
   logic [PW-1:0] rob_prd_new;
   logic [PW-1:0] rob_prd_old;
   logic          wb_en;
   logic [PW-1:0] wb_prd;
   logic          commit_valid;
   logic [PW-1:0] commit_prd_old;
   logic          commit_pop;
   logic [FW-1:0] free_cnt;
   logic          fl_overflow;

   int total;
   int bad;
   logic [PW-1:0] rob_q [$];

   rename_unit #(.ARCH(ARCH), .PHYS(PHYS)) dut (
      .clk            (clk),
      .rst            (rst),
      .ren_valid      (ren_valid),
      .ren_ard        (ren_ard),
      .ren_ars1       (ren_ars1),
      .ren_ars2       (ren_ars2),
      .ren_ready      (ren_ready),
      .ren_prd        (ren_prd),
      .ren_prs1       (ren_prs1),
      .ren_prs2       (ren_prs2),
      .ren_prs1_rdy   (ren_prs1_rdy),
      .ren_prs2_rdy   (ren_prs2_rdy),
      .rob_alloc_ok   (rob_alloc_ok),
      .rob_alloc_en   (rob_alloc_en),
      .rob_ard        (rob_ard),
      .rob_prd_new    (rob_prd_new),
      .rob_prd_old    (rob_prd_old),
      .wb_en          (wb_en),
      .wb_prd         (wb_prd),
      .commit_valid   (commit_valid),
      .commit_prd_old (commit_prd_old),
      .commit_pop     (commit_pop),
      .free_cnt       (free_cnt),
      .fl_overflow    (fl_overflow)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_invariant(input string tag);
      check(tag, int'(free_cnt) + rob_q.size(), 32);
   endtask

   // Retire the oldest in-flight rename
   task automatic commit_one();
      commit_valid   = 1'b1;
      commit_prd_old = rob_q.pop_front();
      step();
      commit_valid   = 1'b0;
   endtask

   // Watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1;
      ren_valid = 1'b0; ren_ard = 5'd0; ren_ars1 = 5'd0; ren_ars2 = 5'd0;
      rob_alloc_ok = 1'b1; wb_en = 1'b0; wb_prd = 6'd0;
      commit_valid = 1'b0; commit_prd_old = 6'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;

      // Reset state
      check("rst_free_cnt", int'(free_cnt), 32);
      check("rst_ren_ready", int'(ren_ready), 1);
      check("rst_overflow", int'(fl_overflow), 0);
      check("rst_alloc_en", int'(rob_alloc_en), 0);
      check("rst_commit_pop", int'(commit_pop), 0);
      ren_ars1 = 5'd5;
      #1;
      check("rst_prs1", int'(ren_prs1), 5);
      check("rst_prs1_rdy", int'(ren_prs1_rdy), 1);

      // First rename of ard=3; the source equal to ard sees the old mapping
      ren_valid = 1'b1; ren_ard = 5'd3; ren_ars1 = 5'd3; ren_ars2 = 5'd5;
      #1;
      check("r1_prd", int'(ren_prd), 32);
      check("r1_prd_new", int'(rob_prd_new), 32);
      check("r1_prd_old", int'(rob_prd_old), 3);
      check("r1_ard", int'(rob_ard), 3);
      check("r1_alloc_en", int'(rob_alloc_en), 1);
      check("r1_prs1_old_map", int'(ren_prs1), 3);
      check("r1_prs1_rdy", int'(ren_prs1_rdy), 1);
      rob_q.push_back(6'd3);
      step();
      check("r1_free_cnt", int'(free_cnt), 31);

      // Back-to-back rename of ard=3 with ars1=3
      #1;
      check("r2_prd", int'(ren_prd), 33);
      check("r2_prd_old", int'(rob_prd_old), 32);
      check("r2_prs1", int'(ren_prs1), 32);
      check("r2_prs1_busy", int'(ren_prs1_rdy), 0);
      check("r2_prs2", int'(ren_prs2), 5);
      rob_q.push_back(6'd32);
      step();
      check("r2_free_cnt", int'(free_cnt), 30);

      // Same-cycle writeback bypass, then the busy bit stays cleared
      ren_valid = 1'b0;
      #1;
      check("wb_prs1", int'(ren_prs1), 33);
      check("wb_pre_rdy", int'(ren_prs1_rdy), 0);
      wb_en = 1'b1; wb_prd = 6'd33;
      #1;
      check("wb_bypass_rdy", int'(ren_prs1_rdy), 1);
      step();
      wb_en = 1'b0;
      #1;
      check("wb_busy_cleared", int'(ren_prs1_rdy), 1);
      check_invariant("inv_after_wb");

      // Drain the remaining 30 free registers with ard = 0..29
      for (int i = 0; i < 30; i++) begin
         ren_valid = 1'b1;
         ren_ard   = AW'(i);
         #1;
         check("fill_prd", int'(ren_prd), 34 + i);
         check("fill_prd_old", int'(rob_prd_old), (i == 3) ? 33 : i);
         rob_q.push_back(PW'((i == 3) ? 33 : i));
         step();
      end

      // Empty free list blocks renaming
      ren_ard = 5'd7;
      #1;
      check("empty_free_cnt", int'(free_cnt), 0);
      check("empty_ready", int'(ren_ready), 0);
      check("empty_alloc_en", int'(rob_alloc_en), 0);
      check_invariant("inv_empty");

      // A commit does not unblock rename in its own cycle
      commit_valid   = 1'b1;
      commit_prd_old = rob_q.pop_front();
      #1;
      check("empty_commit_pop", int'(commit_pop), 1);
      check("empty_commit_ready", int'(ren_ready), 0);
      check("empty_commit_alloc", int'(rob_alloc_en), 0);
      step();
      commit_valid = 1'b0;
      ren_valid    = 1'b0;
      #1;
      check("refill_free_cnt", int'(free_cnt), 1);
      check("refill_prd", int'(ren_prd), 3);
      check("refill_ready", int'(ren_ready), 1);

      // Bring the count to 10
      for (int i = 0; i < 9; i++) begin
         commit_one();
      end
      check("ten_free_cnt", int'(free_cnt), 10);

      // Simultaneous fire and commit leave the count unchanged
      ren_valid      = 1'b1;
      ren_ard        = 5'd9;
      commit_valid   = 1'b1;
      commit_prd_old = rob_q.pop_front();
      #1;
      check("both_prd", int'(ren_prd), 3);
      check("both_prd_old", int'(rob_prd_old), 43);
      check("both_alloc_en", int'(rob_alloc_en), 1);
      check("both_commit_pop", int'(commit_pop), 1);
      rob_q.push_back(6'd43);
      step();
      ren_valid    = 1'b0;
      commit_valid = 1'b0;
      #1;
      check("both_free_cnt", int'(free_cnt), 10);
      check("both_next_prd", int'(ren_prd), 32);
      check_invariant("inv_both");

      // Retire everything, then push once more while full
      while (rob_q.size() > 0) begin
         commit_one();
      end
      check("full_free_cnt", int'(free_cnt), 32);
      check("full_no_ovf", int'(fl_overflow), 0);
      commit_valid   = 1'b1;
      commit_prd_old = 6'd50;
      step();
      commit_valid = 1'b0;
      #1;
      check("ovf_flag", int'(fl_overflow), 1);
      check("ovf_free_cnt", int'(free_cnt), 32);
      check("ovf_list_intact", int'(ren_prd), 32);
      step();
      check("ovf_sticky", int'(fl_overflow), 1);

      // Rename ard=4, then assert async reset between clock edges
      ren_valid = 1'b1;
      ren_ard   = 5'd4;
      step();
      ren_valid = 1'b0;
      ren_ars1  = 5'd4;
      #1;
      check("pre_rst_prs1", int'(ren_prs1), 32);
      check("pre_rst_rdy", int'(ren_prs1_rdy), 0);
      check("pre_rst_free_cnt", int'(free_cnt), 31);
      #1 rst = 1'b1;
      #1;
      check("arst_free_cnt", int'(free_cnt), 32);
      check("arst_overflow", int'(fl_overflow), 0);
      check("arst_prs1", int'(ren_prs1), 4);
      check("arst_prs1_rdy", int'(ren_prs1_rdy), 1);
      check("arst_prd", int'(ren_prd), 32);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready", int'(ren_ready), 1);
      check("post_rst_free_cnt", int'(free_cnt), 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
